// File: rtl/dram_request_arbiter_if.sv
// Request/response pipes between two requesters, the arbiter and the DRAM bridge.
// The slave modport is the arbiter's view; master is the environment's view.
interface dram_request_arbiter_if;
  logic         R0_REQUEST_pipe_write_req;
  logic         R0_REQUEST_pipe_write_ack;
  logic [109:0] R0_REQUEST_pipe_write_data;
  logic         R1_REQUEST_pipe_write_req;
  logic         R1_REQUEST_pipe_write_ack;
  logic [109:0] R1_REQUEST_pipe_write_data;
  logic         R0_RESPONSE_pipe_read_req;
  logic         R0_RESPONSE_pipe_read_ack;
  logic [64:0]  R0_RESPONSE_pipe_read_data;
  logic         R1_RESPONSE_pipe_read_req;
  logic         R1_RESPONSE_pipe_read_ack;
  logic [64:0]  R1_RESPONSE_pipe_read_data;
  logic         DRAM_REQUEST_pipe_write_req;
  logic         DRAM_REQUEST_pipe_write_ack;
  logic [109:0] DRAM_REQUEST_pipe_write_data;
  logic         DRAM_RESPONSE_pipe_read_req;
  logic         DRAM_RESPONSE_pipe_read_ack;
  logic [64:0]  DRAM_RESPONSE_pipe_read_data;
  logic [3:0]   outstanding;

  modport slave (
    input  R0_REQUEST_pipe_write_req, R0_REQUEST_pipe_write_data,
    input  R1_REQUEST_pipe_write_req, R1_REQUEST_pipe_write_data,
    input  R0_RESPONSE_pipe_read_req, R1_RESPONSE_pipe_read_req,
    input  DRAM_REQUEST_pipe_write_ack,
    input  DRAM_RESPONSE_pipe_read_ack, DRAM_RESPONSE_pipe_read_data,
    output R0_REQUEST_pipe_write_ack, R1_REQUEST_pipe_write_ack,
    output R0_RESPONSE_pipe_read_ack, R0_RESPONSE_pipe_read_data,
    output R1_RESPONSE_pipe_read_ack, R1_RESPONSE_pipe_read_data,
    output DRAM_REQUEST_pipe_write_req, DRAM_REQUEST_pipe_write_data,
    output DRAM_RESPONSE_pipe_read_req,
    output outstanding
  );

  modport master (
    output R0_REQUEST_pipe_write_req, R0_REQUEST_pipe_write_data,
    output R1_REQUEST_pipe_write_req, R1_REQUEST_pipe_write_data,
    output R0_RESPONSE_pipe_read_req, R1_RESPONSE_pipe_read_req,
    output DRAM_REQUEST_pipe_write_ack,
    output DRAM_RESPONSE_pipe_read_ack, DRAM_RESPONSE_pipe_read_data,
    input  R0_REQUEST_pipe_write_ack, R1_REQUEST_pipe_write_ack,
    input  R0_RESPONSE_pipe_read_ack, R0_RESPONSE_pipe_read_data,
    input  R1_RESPONSE_pipe_read_ack, R1_RESPONSE_pipe_read_data,
    input  DRAM_REQUEST_pipe_write_req, DRAM_REQUEST_pipe_write_data,
    input  DRAM_RESPONSE_pipe_read_req,
    input  outstanding
  );
endinterface

// File: rtl/dram_request_arbiter.sv
// Two-requester arbiter in front of a DRAM bridge with an in-order ID FIFO for response routing.
// Define DRAM_ARB_FIXED_PRIORITY_EN to make R0 always win contention instead of round robin.
module dram_request_arbiter #(
  parameter int ID_DEPTH = 8
) (
  input logic                   ui_clk,
  input logic                   sys_rst_n,
  dram_request_arbiter_if.slave bus
);
  localparam int PW = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(ID_DEPTH - 1);
  localparam logic [4:0] DEPTH_W = 5'(ID_DEPTH);

  logic                buf_valid_r;
  logic [109:0]        buf_data_r;
  logic                buf_id_r;
  logic [ID_DEPTH-1:0] id_fifo_r;
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [3:0]          count_r;
`ifndef DRAM_ARB_FIXED_PRIORITY_EN
  logic                last_grant_r;
`endif

  logic         fifo_empty_s;
  logic         head_id_s;
  logic         dram_xfer_s;
  logic         buf_free_s;
  logic         space_s;
  logic         can_grant_s;
  logic         grant_valid_s;
  logic         grant_id_s;
  logic [109:0] grant_data_s;
  logic         ack0_s;
  logic         ack1_s;
  logic         accept_s;
  logic         resp_ready_s;
  logic         dram_resp_req_s;
  logic         resp_ack_s;
  logic         resp_xfer_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    if (ptr == PTR_LAST) begin
      next_ptr = {PW{1'b0}};
    end else begin
      next_ptr = ptr + PW'(1'b1);
    end
  endfunction

  // Arbitration, buffer availability and response routing decode
  always_comb begin
    fifo_empty_s  = (count_r == 4'd0);
    head_id_s     = id_fifo_r[rd_ptr_r];
    dram_xfer_s   = buf_valid_r & bus.DRAM_REQUEST_pipe_write_ack;
    buf_free_s    = ~buf_valid_r | bus.DRAM_REQUEST_pipe_write_ack;
    // Count the buffered request too, so the FIFO can never be pushed while full.
    space_s       = ({1'b0, count_r} + {4'b0000, buf_valid_r}) < DEPTH_W;
    can_grant_s   = sys_rst_n & buf_free_s & space_s;
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    case ({bus.R1_REQUEST_pipe_write_req, bus.R0_REQUEST_pipe_write_req})
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
`ifdef DRAM_ARB_FIXED_PRIORITY_EN
        grant_id_s    = 1'b0;
`else
        grant_id_s    = ~last_grant_r;
`endif
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    endcase
    grant_data_s    = grant_id_s ? bus.R1_REQUEST_pipe_write_data : bus.R0_REQUEST_pipe_write_data;
    ack0_s          = can_grant_s & grant_valid_s & ~grant_id_s;
    ack1_s          = can_grant_s & grant_valid_s & grant_id_s;
    accept_s        = ack0_s | ack1_s;
    resp_ready_s    = head_id_s ? bus.R1_RESPONSE_pipe_read_req : bus.R0_RESPONSE_pipe_read_req;
    dram_resp_req_s = ~fifo_empty_s & resp_ready_s;
    resp_ack_s      = ~fifo_empty_s & bus.DRAM_RESPONSE_pipe_read_ack;
    resp_xfer_s     = dram_resp_req_s & bus.DRAM_RESPONSE_pipe_read_ack;
  end

  assign bus.R0_REQUEST_pipe_write_ack    = ack0_s;
  assign bus.R1_REQUEST_pipe_write_ack    = ack1_s;
  assign bus.DRAM_REQUEST_pipe_write_req  = buf_valid_r;
  assign bus.DRAM_REQUEST_pipe_write_data = buf_data_r;
  assign bus.DRAM_RESPONSE_pipe_read_req  = dram_resp_req_s;
  assign bus.R0_RESPONSE_pipe_read_ack    = resp_ack_s & ~head_id_s;
  assign bus.R1_RESPONSE_pipe_read_ack    = resp_ack_s & head_id_s;
  assign bus.R0_RESPONSE_pipe_read_data   = bus.DRAM_RESPONSE_pipe_read_data;
  assign bus.R1_RESPONSE_pipe_read_data   = bus.DRAM_RESPONSE_pipe_read_data;
  assign bus.outstanding                  = count_r;

  // One-entry output buffer toward the DRAM bridge
  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      buf_valid_r <= 1'b0;
      buf_data_r  <= {110{1'b0}};
      buf_id_r    <= 1'b0;
    end else if (accept_s) begin
      buf_valid_r <= 1'b1;
      buf_data_r  <= grant_data_s;
      buf_id_r    <= grant_id_s;
    end else if (dram_xfer_s) begin
      buf_valid_r <= 1'b0;
    end
  end

`ifndef DRAM_ARB_FIXED_PRIORITY_EN
  // Last granted requester; reset to 1 so R0 wins the first contention
  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      last_grant_r <= grant_id_s;
    end
  end
`endif

  // ID FIFO: pushed as requests leave, popped as responses are delivered
  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      id_fifo_r <= {ID_DEPTH{1'b0}};
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      count_r   <= 4'd0;
    end else begin
      if (dram_xfer_s) begin
        id_fifo_r[wr_ptr_r] <= buf_id_r;
        wr_ptr_r            <= next_ptr(wr_ptr_r);
      end
      if (resp_xfer_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({dram_xfer_s, resp_xfer_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_request_arbiter.sv
// Directed bench for dram_request_arbiter: a queue-based model of the arbitration and
// in-order response rules is compared against the DUT on every falling clock edge.
module tb_dram_request_arbiter;
  localparam int ID_DEPTH = 8;
`ifdef DRAM_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic ui_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  dram_request_arbiter_if bus ();

  dram_request_arbiter #(.ID_DEPTH(ID_DEPTH)) dut (
    .ui_clk(ui_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus)
  );

  always #5 ui_clk = ~ui_clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: the buffered request, the IDs awaiting responses and the last winner.
  bit           m_bv;
  logic [109:0] m_bdata;
  bit           m_bid;
  bit           m_ids[$];
  bit           m_last;
  int           g_id[$];
  logic [109:0] g_data[$];
  int           r_who[$];
  logic [64:0]  r_data[$];

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [109:0] pat(input int k, input int i);
    logic [109:0] v;
    v = {110{1'b0}};
    v[109:96] = 14'(k);
    v[15:0] = 16'(16'hA000 + i);
    return v;
  endfunction

  // Per-cycle compare against the model, then advance the model across the next rising edge
  always @(negedge ui_clk) begin
    int n;
    bit h, free, space, grant, win, push, pop;
    if (!sys_rst_n) begin
      chkb("rst_dram_req", bus.DRAM_REQUEST_pipe_write_req, 1'b0);
      chkb("rst_r0_ack", bus.R0_REQUEST_pipe_write_ack, 1'b0);
      chkb("rst_r1_ack", bus.R1_REQUEST_pipe_write_ack, 1'b0);
      chkb("rst_dram_resp_req", bus.DRAM_RESPONSE_pipe_read_req, 1'b0);
      chkb("rst_r0_resp_ack", bus.R0_RESPONSE_pipe_read_ack, 1'b0);
      chkb("rst_r1_resp_ack", bus.R1_RESPONSE_pipe_read_ack, 1'b0);
      chkw("rst_outstanding", 128'(bus.outstanding), 128'd0);
      m_bv = 1'b0;
      m_bid = 1'b0;
      m_ids.delete();
      m_last = 1'b1;
    end else begin
      n = m_ids.size();
      h = (n > 0) ? m_ids[0] : 1'b0;
      free = !m_bv || bus.DRAM_REQUEST_pipe_write_ack;
      space = (n + int'(m_bv)) < ID_DEPTH;
      grant = free && space && (bus.R0_REQUEST_pipe_write_req || bus.R1_REQUEST_pipe_write_req);
      if (bus.R0_REQUEST_pipe_write_req && bus.R1_REQUEST_pipe_write_req) win = FIXED ? 1'b0 : !m_last;
      else win = bus.R1_REQUEST_pipe_write_req;

      chkb("dram_req", bus.DRAM_REQUEST_pipe_write_req, m_bv);
      if (m_bv) chkw("dram_data", 128'(bus.DRAM_REQUEST_pipe_write_data), 128'(m_bdata));
      chkb("r0_req_ack", bus.R0_REQUEST_pipe_write_ack, grant && !win);
      chkb("r1_req_ack", bus.R1_REQUEST_pipe_write_ack, grant && win);
      chkb("dram_resp_req", bus.DRAM_RESPONSE_pipe_read_req,
           (n > 0) && (h ? bus.R1_RESPONSE_pipe_read_req : bus.R0_RESPONSE_pipe_read_req));
      chkb("r0_resp_ack", bus.R0_RESPONSE_pipe_read_ack, (n > 0) && bus.DRAM_RESPONSE_pipe_read_ack && !h);
      chkb("r1_resp_ack", bus.R1_RESPONSE_pipe_read_ack, (n > 0) && bus.DRAM_RESPONSE_pipe_read_ack && h);
      chkw("r0_resp_data", 128'(bus.R0_RESPONSE_pipe_read_data), 128'(bus.DRAM_RESPONSE_pipe_read_data));
      chkw("r1_resp_data", 128'(bus.R1_RESPONSE_pipe_read_data), 128'(bus.DRAM_RESPONSE_pipe_read_data));
      chkw("outstanding", 128'(bus.outstanding), 128'(n));

      push = m_bv && bus.DRAM_REQUEST_pipe_write_ack;
      pop = (n > 0) && bus.DRAM_RESPONSE_pipe_read_ack &&
            (h ? bus.R1_RESPONSE_pipe_read_req : bus.R0_RESPONSE_pipe_read_req);
      if (pop) begin
        r_who.push_back(int'(h));
        r_data.push_back(bus.DRAM_RESPONSE_pipe_read_data);
        void'(m_ids.pop_front());
      end
      if (push) m_ids.push_back(m_bid);
      if (grant) begin
        m_bv = 1'b1;
        m_bdata = win ? bus.R1_REQUEST_pipe_write_data : bus.R0_REQUEST_pipe_write_data;
        m_bid = win;
        m_last = win;
        g_id.push_back(int'(win));
        g_data.push_back(m_bdata);
      end else if (push) begin
        m_bv = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge ui_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.R0_REQUEST_pipe_write_req = 1'b0;
    bus.R0_REQUEST_pipe_write_data = {110{1'b0}};
    bus.R1_REQUEST_pipe_write_req = 1'b0;
    bus.R1_REQUEST_pipe_write_data = {110{1'b0}};
    bus.R0_RESPONSE_pipe_read_req = 1'b0;
    bus.R1_RESPONSE_pipe_read_req = 1'b0;
    bus.DRAM_REQUEST_pipe_write_ack = 1'b0;
    bus.DRAM_RESPONSE_pipe_read_ack = 1'b0;
    bus.DRAM_RESPONSE_pipe_read_data = {65{1'b0}};
  endtask

  task automatic do_reset();
    idle_inputs();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  logic [109:0] d;
  int acc;

  initial begin
    idle_inputs();
    sys_rst_n = 1'b0;

    // Single R0 read: one-cycle latency, response routed to R0 only
    do_reset();
    bus.DRAM_REQUEST_pipe_write_ack = 1'b1;
    bus.R0_RESPONSE_pipe_read_req = 1'b1;
    bus.R1_RESPONSE_pipe_read_req = 1'b1;
    d = {110{1'b0}};
    d[108] = 1'b1;
    d[31:0] = 32'hA000_0001;
    bus.R0_REQUEST_pipe_write_data = d;
    bus.R0_REQUEST_pipe_write_req = 1'b1;
    mid();
    chkb("t1_accept", bus.R0_REQUEST_pipe_write_ack, 1'b1);
    chkb("t1_r1_idle", bus.R1_REQUEST_pipe_write_ack, 1'b0);
    tick();
    bus.R0_REQUEST_pipe_write_req = 1'b0;
    mid();
    chkb("t1_latency", bus.DRAM_REQUEST_pipe_write_req, 1'b1);
    chkw("t1_fwd_data", 128'(bus.DRAM_REQUEST_pipe_write_data), 128'(d));
    tick();
    mid();
    chkw("t1_outstanding_1", 128'(bus.outstanding), 128'd1);
    tick();
    bus.DRAM_RESPONSE_pipe_read_data = 65'h1_0000_0000_CAFE_0001;
    bus.DRAM_RESPONSE_pipe_read_ack = 1'b1;
    mid();
    chkb("t1_r0_resp_ack", bus.R0_RESPONSE_pipe_read_ack, 1'b1);
    chkb("t1_r1_resp_ack", bus.R1_RESPONSE_pipe_read_ack, 1'b0);
    chkw("t1_r0_resp_data", 128'(bus.R0_RESPONSE_pipe_read_data), 128'h1_0000_0000_CAFE_0001);
    tick();
    bus.DRAM_RESPONSE_pipe_read_ack = 1'b0;
    mid();
    chkw("t1_outstanding_0", 128'(bus.outstanding), 128'd0);

    // Both requesters every cycle: alternate from R0 (or R0 only under fixed priority)
    do_reset();
    g_id.delete();
    g_data.delete();
    bus.DRAM_REQUEST_pipe_write_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.R0_REQUEST_pipe_write_req = 1'b1;
      bus.R1_REQUEST_pipe_write_req = 1'b1;
      bus.R0_REQUEST_pipe_write_data = pat(0, i);
      bus.R1_REQUEST_pipe_write_data = pat(1, i);
      tick();
    end
    bus.R0_REQUEST_pipe_write_req = 1'b0;
    bus.R1_REQUEST_pipe_write_req = 1'b0;
    tick();
    tick();
    chkw("t2_grant_count", 128'(g_id.size()), 128'd4);
    for (int i = 0; i < 4; i++) begin
      chkw("t2_grant_id", (i < g_id.size()) ? 128'(g_id[i]) : 128'hDEAD,
           (FIXED || (i % 2 == 0)) ? 128'd0 : 128'd1);
      chkw("t2_grant_data", (i < g_data.size()) ? 128'(g_data[i]) : 128'hDEAD,
           (FIXED || (i % 2 == 0)) ? 128'(pat(0, i)) : 128'(pat(1, i)));
    end

    // Eight unanswered requests fill the ID FIFO; acceptance resumes after one pop
    do_reset();
    bus.DRAM_REQUEST_pipe_write_ack = 1'b1;
    bus.R0_REQUEST_pipe_write_data = pat(0, 100);
    acc = 0;
    for (int c = 0; c < 30 && acc < 8; c++) begin
      bus.R0_REQUEST_pipe_write_req = 1'b1;
      mid();
      if (bus.R0_REQUEST_pipe_write_ack) acc++;
      tick();
    end
    bus.R0_REQUEST_pipe_write_req = 1'b0;
    chkw("t3_accepts", 128'(acc), 128'd8);
    tick();
    tick();
    mid();
    chkw("t3_outstanding_8", 128'(bus.outstanding), 128'd8);
    tick();
    bus.R0_REQUEST_pipe_write_req = 1'b1;
    bus.R1_REQUEST_pipe_write_req = 1'b1;
    mid();
    chkb("t3_full_r0", bus.R0_REQUEST_pipe_write_ack, 1'b0);
    chkb("t3_full_r1", bus.R1_REQUEST_pipe_write_ack, 1'b0);
    tick();
    bus.R1_REQUEST_pipe_write_req = 1'b0;
    bus.R0_RESPONSE_pipe_read_req = 1'b1;
    bus.R1_RESPONSE_pipe_read_req = 1'b1;
    bus.DRAM_RESPONSE_pipe_read_data = 65'h0_0000_0000_0000_0042;
    bus.DRAM_RESPONSE_pipe_read_ack = 1'b1;
    mid();
    chkb("t3_still_full", bus.R0_REQUEST_pipe_write_ack, 1'b0);
    tick();
    bus.DRAM_RESPONSE_pipe_read_ack = 1'b0;
    mid();
    chkw("t3_outstanding_7", 128'(bus.outstanding), 128'd7);
    chkb("t3_reopen", bus.R0_REQUEST_pipe_write_ack, 1'b1);
    tick();
    bus.R0_REQUEST_pipe_write_req = 1'b0;

    // Issue R1,R0,R1; responses return in issue order, head=0 with R0 not ready stalls
    do_reset();
    r_who.delete();
    r_data.delete();
    bus.DRAM_REQUEST_pipe_write_ack = 1'b1;
    bus.R1_REQUEST_pipe_write_data = pat(1, 1);
    bus.R1_REQUEST_pipe_write_req = 1'b1;
    tick();
    bus.R1_REQUEST_pipe_write_req = 1'b0;
    bus.R0_REQUEST_pipe_write_data = pat(0, 2);
    bus.R0_REQUEST_pipe_write_req = 1'b1;
    tick();
    bus.R0_REQUEST_pipe_write_req = 1'b0;
    bus.R1_REQUEST_pipe_write_data = pat(1, 3);
    bus.R1_REQUEST_pipe_write_req = 1'b1;
    tick();
    bus.R1_REQUEST_pipe_write_req = 1'b0;
    tick();
    tick();
    mid();
    chkw("t4_outstanding_3", 128'(bus.outstanding), 128'd3);
    tick();
    bus.R0_RESPONSE_pipe_read_req = 1'b0;
    bus.R1_RESPONSE_pipe_read_req = 1'b1;
    bus.DRAM_RESPONSE_pipe_read_ack = 1'b1;
    bus.DRAM_RESPONSE_pipe_read_data = 65'h0_0000_0000_0000_0D01;
    mid();
    chkb("t4_d1_req", bus.DRAM_RESPONSE_pipe_read_req, 1'b1);
    chkb("t4_d1_r1", bus.R1_RESPONSE_pipe_read_ack, 1'b1);
    tick();
    bus.DRAM_RESPONSE_pipe_read_data = 65'h0_0000_0000_0000_0D02;
    mid();
    chkb("t4_stall", bus.DRAM_RESPONSE_pipe_read_req, 1'b0);
    tick();
    mid();
    chkw("t4_held", 128'(bus.outstanding), 128'd2);
    tick();
    bus.R0_RESPONSE_pipe_read_req = 1'b1;
    mid();
    chkb("t4_d2_req", bus.DRAM_RESPONSE_pipe_read_req, 1'b1);
    tick();
    bus.DRAM_RESPONSE_pipe_read_data = 65'h0_0000_0000_0000_0D03;
    mid();
    chkb("t4_d3_r1", bus.R1_RESPONSE_pipe_read_ack, 1'b1);
    tick();
    bus.DRAM_RESPONSE_pipe_read_ack = 1'b0;
    mid();
    chkw("t4_drained", 128'(bus.outstanding), 128'd0);
    chkw("t4_resp_count", 128'(r_who.size()), 128'd3);
    for (int i = 0; i < 3; i++) begin
      chkw("t4_resp_who", (i < r_who.size()) ? 128'(r_who[i]) : 128'hDEAD,
           (i == 1) ? 128'd0 : 128'd1);
      chkw("t4_resp_data", (i < r_data.size()) ? 128'(r_data[i]) : 128'hDEAD,
           128'(12'hD01 + i));
    end

    // Simultaneous push and pop at outstanding 3, then reset mid-burst
    do_reset();
    bus.DRAM_REQUEST_pipe_write_ack = 1'b1;
    bus.R0_REQUEST_pipe_write_data = pat(0, 5);
    bus.R0_REQUEST_pipe_write_req = 1'b1;
    tick();
    tick();
    tick();
    bus.R0_REQUEST_pipe_write_req = 1'b0;
    tick();
    bus.R0_REQUEST_pipe_write_req = 1'b1;
    tick();
    bus.R0_REQUEST_pipe_write_req = 1'b0;
    bus.R0_RESPONSE_pipe_read_req = 1'b1;
    bus.DRAM_RESPONSE_pipe_read_ack = 1'b1;
    bus.DRAM_RESPONSE_pipe_read_data = 65'h0_0000_0000_0000_0555;
    mid();
    chkw("t5_before", 128'(bus.outstanding), 128'd3);
    chkb("t5_push_side", bus.DRAM_REQUEST_pipe_write_req, 1'b1);
    chkb("t5_pop_side", bus.DRAM_RESPONSE_pipe_read_req, 1'b1);
    tick();
    bus.DRAM_RESPONSE_pipe_read_ack = 1'b0;
    mid();
    chkw("t5_push_pop", 128'(bus.outstanding), 128'd3);
    tick();
    bus.R0_REQUEST_pipe_write_req = 1'b1;
    bus.R1_REQUEST_pipe_write_req = 1'b1;
    bus.R1_RESPONSE_pipe_read_req = 1'b1;
    bus.DRAM_RESPONSE_pipe_read_ack = 1'b1;
    tick();
    tick();
    #2;
    sys_rst_n = 1'b0;
    #1;
    chkb("t6_rst_dram_req", bus.DRAM_REQUEST_pipe_write_req, 1'b0);
    chkb("t6_rst_r0_ack", bus.R0_REQUEST_pipe_write_ack, 1'b0);
    chkb("t6_rst_r1_ack", bus.R1_REQUEST_pipe_write_ack, 1'b0);
    chkb("t6_rst_dram_resp_req", bus.DRAM_RESPONSE_pipe_read_req, 1'b0);
    chkb("t6_rst_r0_resp_ack", bus.R0_RESPONSE_pipe_read_ack, 1'b0);
    chkb("t6_rst_r1_resp_ack", bus.R1_RESPONSE_pipe_read_ack, 1'b0);
    chkw("t6_rst_outstanding", 128'(bus.outstanding), 128'd0);
    tick();
    sys_rst_n = 1'b1;
    bus.R1_REQUEST_pipe_write_req = 1'b0;
    bus.DRAM_RESPONSE_pipe_read_ack = 1'b0;
    mid();
    chkb("t6_resume_ack", bus.R0_REQUEST_pipe_write_ack, 1'b1);
    tick();
    bus.R0_REQUEST_pipe_write_req = 1'b0;
    mid();
    chkb("t6_resume_fwd", bus.DRAM_REQUEST_pipe_write_req, 1'b1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
